// File: rtl/microwave_ctrl.sv
// Microwave cook controller.
// Collects keypad digits into a BCD MM:SS cook time, counts it down on the
// 1 Hz tick while cooking, drives the magnetron and the done alarm, and
// locks the keypad encoder out (enablen) during COOK and DONE.
// Ports:
//   clk, clear          clock and asynchronous active-high reset
//   D, loadn            keypad BCD digit and active-low key-valid strobe
//   pgt_1hz             1 Hz tick, synchronous to clk
//   start, stop         buttons (level, active-high)
//   door_closed         1 = door closed
//   enablen             keypad enable to encoder (active-low)
//   magnetron_on, done  cook and alarm outputs
//   min_tens..sec_ones  BCD display digits
//   state               encoded FSM state (IDLE=0 .. DONE=4)
module microwave_ctrl #(
    parameter int unsigned DONE_HOLD_TICKS = 3
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1hz,
    input  logic       start,
    input  logic       stop,
    input  logic       door_closed,
    output logic       enablen,
    output logic       magnetron_on,
    output logic       done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [2:0] state
);

    localparam int unsigned TIME_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                loadn_q, pgt_q;
    logic                mag_q, done_q, en_q;

    logic                key_evt, key_ok, tick, time_zero;
    logic [TIME_W-1:0]   time_shift, time_dec;
    logic [CNT_W-1:0]    cnt_inc;

    // Edge detection against registered copies of the strobes
    assign key_evt   = loadn_q & ~loadn;
    assign key_ok    = key_evt && (D <= 4'd9);
    assign tick      = ~pgt_q & pgt_1hz;
    assign time_zero = (time_q == '0);
    assign time_shift = {time_q[11:0], D};
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // One-step BCD countdown; seconds above 59 count down as entered
    always_comb begin
        time_dec = time_q;
        if (time_q[3:0] != 4'd0) begin
            time_dec[3:0] = time_q[3:0] - 4'd1;
        end else if (time_q[7:4] != 4'd0) begin
            time_dec[3:0] = 4'd9;
            time_dec[7:4] = time_q[7:4] - 4'd1;
        end else if (time_q[11:8] != 4'd0) begin
            time_dec[7:0]  = 8'h59;
            time_dec[11:8] = time_q[11:8] - 4'd1;
        end else begin
            time_dec[7:0]   = 8'h59;
            time_dec[11:8]  = 4'd9;
            time_dec[15:12] = time_q[15:12] - 4'd1;
        end
    end

    // Next-state logic; priority stop > door open > start > key/tick
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!stop && key_ok) begin
                    time_d  = time_shift;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (stop) begin
                    time_d  = '0;
                    state_d = ST_IDLE;
                end else if (start && door_closed && !time_zero) begin
                    state_d = ST_COOK;
                end else if (key_ok) begin
                    time_d = time_shift;
                end
            end
            ST_COOK: begin
                if (stop || !door_closed) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    time_d = time_dec;
                    if (time_dec == '0) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    time_d  = '0;
                    state_d = ST_IDLE;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (stop || !door_closed) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(DONE_HOLD_TICKS)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                time_d  = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs (decoded from next state)
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            cnt_q   <= '0;
            loadn_q <= 1'b1;
            pgt_q   <= 1'b1;
            mag_q   <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            cnt_q   <= cnt_d;
            loadn_q <= loadn;
            pgt_q   <= pgt_1hz;
            mag_q   <= (state_d == ST_COOK);
            done_q  <= (state_d == ST_DONE);
            en_q    <= (state_d == ST_COOK) || (state_d == ST_DONE);
        end
    end

    assign state        = state_q;
    assign magnetron_on = mag_q;
    assign done         = done_q;
    assign enablen      = en_q;
    assign min_tens     = time_q[15:12];
    assign min_ones     = time_q[11:8];
    assign sec_tens     = time_q[7:4];
    assign sec_ones     = time_q[3:0];

endmodule

// File: tb/tb_microwave_ctrl.sv
// Directed, scoreboard-checked bench for microwave_ctrl.
module tb_microwave_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_COOK = 3'd2,
                           S_PAUSE = 3'd3, S_DONE = 3'd4;

    logic       clk = 1'b0;
    logic       clear, loadn, pgt_1hz, start, stop, door_closed;
    logic [3:0] D;
    logic       enablen, magnetron_on, done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state;

    microwave_ctrl #(.DONE_HOLD_TICKS(3)) dut (
        .clk(clk), .clear(clear), .D(D), .loadn(loadn), .pgt_1hz(pgt_1hz),
        .start(start), .stop(stop), .door_closed(door_closed),
        .enablen(enablen), .magnetron_on(magnetron_on), .done(done),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  st;
        logic [15:0] t;
        logic        mag;
        logic        dn;
        logic        en;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   drain_chk = 1'b0;
    bit   drain_done = 1'b0;

    // Monitor: pops expectations and compares against the DUT on falling edges
    initial begin : monitor
        exp_t        e;
        logic [15:0] t_act;
        forever begin
            @(negedge clk);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t_act = {min_tens, min_ones, sec_tens, sec_ones};
                checks++;
                if (state !== e.st || t_act !== e.t || magnetron_on !== e.mag ||
                    done !== e.dn || enablen !== e.en) begin
                    errors++;
                    $display("FAIL %s: got st=%0d t=%h mag=%b done=%b en=%b, want st=%0d t=%h mag=%b done=%b en=%b",
                             e.name, state, t_act, magnetron_on, done, enablen,
                             e.st, e.t, e.mag, e.dn, e.en);
                end
            end
            if (drain_chk && !drain_done) begin
                drain_done = 1'b1;
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string name, input logic [2:0] st, input logic [15:0] t,
                             input logic mag, input logic dn, input logic en);
        exp_t e;
        e.name = name; e.st = st; e.t = t; e.mag = mag; e.dn = dn; e.en = en;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] d);
        D = d; loadn = 1'b0;
        step(5);
        loadn = 1'b1;
        step(1);
    endtask

    task automatic tick();
        pgt_1hz = 1'b1;
        step(1);
        pgt_1hz = 1'b0;
        step(1);
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0; step(1);
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(1); stop = 1'b0; step(1);
    endtask

    initial begin : stimulus
        clear = 1'b1; D = 4'd0; loadn = 1'b1; pgt_1hz = 1'b0;
        start = 1'b0; stop = 1'b0; door_closed = 1'b1;
        step(2);
        expect_st("reset", S_IDLE, 16'h0000, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        step(1);

        // Digit entry: one shift per press despite a long strobe
        press(4'd1);
        expect_st("key1", S_SETUP, 16'h0001, 1'b0, 1'b0, 1'b0);
        press(4'd3); press(4'd0);
        expect_st("key130", S_SETUP, 16'h0130, 1'b0, 1'b0, 1'b0);
        press(4'd12);
        expect_st("key_gt9", S_SETUP, 16'h0130, 1'b0, 1'b0, 1'b0);
        pulse_stop();
        expect_st("setup_stop", S_IDLE, 16'h0000, 1'b0, 1'b0, 1'b0);

        // 00:03 full cook and done hold
        press(4'd0); press(4'd0); press(4'd3);
        expect_st("setup003", S_SETUP, 16'h0003, 1'b0, 1'b0, 1'b0);
        pulse_start();
        expect_st("cook_entry", S_COOK, 16'h0003, 1'b1, 1'b0, 1'b1);
        tick();
        expect_st("cook_t1", S_COOK, 16'h0002, 1'b1, 1'b0, 1'b1);
        tick();
        expect_st("cook_t2", S_COOK, 16'h0001, 1'b1, 1'b0, 1'b1);
        tick();
        expect_st("done_entry", S_DONE, 16'h0000, 1'b0, 1'b1, 1'b1);
        tick(); tick();
        expect_st("done_hold", S_DONE, 16'h0000, 1'b0, 1'b1, 1'b1);
        tick();
        expect_st("done_exit", S_IDLE, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Minute borrow: 01:00 -> 00:59
        press(4'd1); press(4'd0); press(4'd0);
        pulse_start();
        tick();
        expect_st("dec_0100", S_COOK, 16'h0059, 1'b1, 1'b0, 1'b1);
        pulse_stop();
        expect_st("cook_stop", S_PAUSE, 16'h0059, 1'b0, 1'b0, 1'b0);
        pulse_stop();
        expect_st("pause_stop", S_IDLE, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Ten-minute borrow: 10:00 -> 09:59
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        pulse_start();
        tick();
        expect_st("dec_1000", S_COOK, 16'h0959, 1'b1, 1'b0, 1'b1);
        pulse_stop(); pulse_stop();

        // Seconds above 59 count as entered: 01:99 -> 01:98
        press(4'd1); press(4'd9); press(4'd9);
        pulse_start();
        tick();
        expect_st("dec_0199", S_COOK, 16'h0198, 1'b1, 1'b0, 1'b1);
        pulse_stop(); pulse_stop();

        // Door open pauses and holds time; resume on start
        press(4'd4); press(4'd5);
        pulse_start();
        door_closed = 1'b0;
        step(1);
        expect_st("door_pause", S_PAUSE, 16'h0045, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        expect_st("pause_hold", S_PAUSE, 16'h0045, 1'b0, 1'b0, 1'b0);
        door_closed = 1'b1;
        step(1);
        pulse_start();
        expect_st("resume", S_COOK, 16'h0045, 1'b1, 1'b0, 1'b1);
        tick();
        expect_st("resume_dec", S_COOK, 16'h0044, 1'b1, 1'b0, 1'b1);
        pulse_stop(); pulse_stop();

        // Start with door open stays in SETUP; start+stop goes IDLE
        press(4'd2); press(4'd0);
        door_closed = 1'b0;
        pulse_start();
        expect_st("start_door_open", S_SETUP, 16'h0020, 1'b0, 1'b0, 1'b0);
        door_closed = 1'b1;
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        expect_st("start_and_stop", S_IDLE, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1);

        // Keys ignored in COOK; async clear mid-cook
        press(4'd1); press(4'd0);
        pulse_start();
        press(4'd5);
        expect_st("cook_key_ignored", S_COOK, 16'h0010, 1'b1, 1'b0, 1'b1);
        step(1);
        clear = 1'b1;
        #1;
        expect_st("async_clear", S_IDLE, 16'h0000, 1'b0, 1'b0, 1'b0);
        step(1);
        clear = 1'b0;
        step(2);

        drain_chk = 1'b1;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
- Top-level cook controller for the microwave.
- Takes decoded keypad digits (D with the active-low load strobe loadn) and the 1 Hz tick pgt_1hz from the encoder. Also takes start/stop buttons and the door switch.
- Builds a 4-digit BCD MM:SS cook time, counts it down while cooking, and drives the magnetron, the done alarm, and enablen back to the encoder so the keypad is locked out during cook.

Parameters:
- DONE_HOLD_TICKS, 3: number of pgt_1hz ticks that done stays asserted before auto-return to IDLE (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clear  in  1  asynchronous, active-high reset.
- D  in  4  BCD digit from keypad encoder; valid while loadn low.
- loadn  in  1  active-low key-valid strobe; may stay low for many clk cycles.
- pgt_1hz  in  1  1 Hz tick, synchronous to clk; one tick per 0->1 transition.
- start  in  1  start button, active-high level.
- stop  in  1  stop/cancel button, active-high level.
- door_closed  in  1  1 = door closed.
- enablen  out  1  keypad enable to encoder, active-low; 1 in COOK and DONE, else 0.
- magnetron_on  out  1  high only in COOK.
- done  out  1  high only in DONE.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits.
- state  out  3  encoded FSM state for display/debug: IDLE=0, SETUP=1, COOK=2, PAUSE=3, DONE=4.

Behaviour:
- Reset (clear=1, async):
  - state=IDLE; all digits 0.
  - magnetron_on=0, done=0, enablen=0.
  - Edge-detect registers preset to loadn=1 and pgt_1hz=1, so no spurious edge on release.
  - Done tick counter = 0.
- Edge detection:
  - Key event = loadn 1->0, seen via a registered copy. One event per press regardless of hold length.
  - Tick = pgt_1hz 0->1, seen via a registered copy.
- Digit entry (key event in IDLE or SETUP):
  - Shift left: {min_tens,min_ones,sec_tens,sec_ones} <= {min_ones,sec_tens,sec_ones,D}.
  - D>9 is ignored.
  - From IDLE, a valid key moves to SETUP.
  - Key events in COOK, PAUSE or DONE are ignored.
- FSM transitions. Priority: stop > door open > start > key/tick.
  - IDLE: valid key -> SETUP. start is ignored.
  - SETUP: stop -> IDLE with digits cleared. start & door_closed & time!=0000 -> COOK. start with time 0000 or door open -> stay in SETUP.
  - COOK: stop -> PAUSE. !door_closed -> PAUSE. Otherwise, on tick, decrement the time. If the decremented value is 0000, go to DONE on the same edge.
  - PAUSE: stop -> IDLE with digits cleared. start & door_closed -> COOK. The time is held.
  - DONE: on each tick, increment the done counter. Counter reaching DONE_HOLD_TICKS, or stop, or !door_closed -> IDLE. Digits stay at 0000.
- Decrement (BCD, one step per tick, COOK only):
  - If sec_ones!=0, then sec_ones-1.
  - Else if sec_tens!=0, then sec_ones=9 and sec_tens-1.
  - Else if min_ones!=0, then sec=59 and min_ones-1.
  - Else, min_tens-1, min_ones=9, sec=59.
  - Entered seconds above 59 count down as entered, e.g. 01:99 -> 01:98 -> ... -> 01:00 -> 00:59.
- Timing:
  - magnetron_on and enablen are registered from next-state and change on the same edge as state.
  - No decrement happens on the edge that enters COOK.
  - A tick coincident with stop or door open is dropped.
- Simultaneous events:
  - start and stop together: stop wins.
  - Key event and tick together in SETUP: the key is applied; the tick has no effect outside COOK and DONE.
- Reset mid-cook: magnetron_on drops asynchronously.

Test Plan:
- Reset, then key events D=1,3,0 (loadn held low 5 cycles each) -> state SETUP, digits 01:30, exactly one shift per press, enablen=0.
- From SETUP 00:03 with door closed, pulse start, then 3 ticks:
  - Expect 00:02, 00:01, then DONE.
  - magnetron_on high for exactly 3 ticks; done=1; enablen=1.
  - After 3 more ticks, return to IDLE with done=0.
- COOK at 01:00, one tick -> 00:59. Load 10:00, one tick -> 09:59.
- COOK at 00:45, door_closed->0 -> PAUSE, magnetron_on=0, time held at 00:45 across 2 ticks. Door closes and start pulses -> COOK, resumes at 00:45.
- SETUP 00:20: start with door open -> stays in SETUP. start and stop asserted together -> IDLE, digits 00:00.
- COOK at 00:10: assert clear mid-cycle -> magnetron_on=0 immediately (before next clk edge), digits 0, state IDLE. Keys pressed during COOK (before the reset) cause no digit change.
